// File: rtl/x_event_counter_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : x_event_counter_fsm
//  Purpose  : Counts x events up to a latched terminal count, flags TERM with
//             a level, a one-cycle entry pulse and a sticky overflow.
//  Revision : 1.0  initial release
// ============================================================================
module x_event_counter_fsm #(
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   input  logic             x,
   input  logic             mode,
   input  logic [WIDTH-1:0] term_cnt,
   output logic             y,
   output logic             y_pulse,
   output logic [WIDTH-1:0] count,
   output logic             ovf,
   output logic [1:0]       state
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      COUNT = 2'b01,
      TERM  = 2'b10
   } state_t;

   localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);
   localparam logic [WIDTH:0]   c_INC = (WIDTH + 1)'(1);

   state_t           r_state, w_state;
   logic [WIDTH-1:0] r_count, w_count;
   logic [WIDTH-1:0] r_tc, w_tc;
   logic             r_y, w_y;
   logic             r_pulse, w_pulse;
   logic             r_ovf, w_ovf;
   logic             w_hit;

   // Extra bit keeps the compare exact even when tc_q is the all-ones value.
   assign w_hit = (({1'b0, r_count} + c_INC) == {1'b0, r_tc});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_count <= '0;
         r_tc    <= c_ONE;
         r_y     <= 1'b0;
         r_pulse <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_state <= w_state;
         r_count <= w_count;
         r_tc    <= w_tc;
         r_y     <= w_y;
         r_pulse <= w_pulse;
         r_ovf   <= w_ovf;
      end
   end

   always_comb begin
      w_state = r_state;
      w_count = r_count;
      w_tc    = r_tc;
      w_ovf   = r_ovf;
      w_pulse = 1'b0;
      if (clr) begin
         w_state = IDLE;
         w_count = '0;
         w_ovf   = 1'b0;
      end else if (en) begin
         case (r_state)
            IDLE: begin
               w_state = COUNT;
               w_count = '0;
               w_tc    = (term_cnt == '0) ? c_ONE : term_cnt;
            end
            COUNT: begin
               if (x) begin
                  if (w_hit) begin
                     w_state = TERM;
                     w_count = r_tc;
                     w_pulse = 1'b1;
                  end else begin
                     w_count = r_count + c_ONE;
                  end
               end
            end
            TERM: begin
               if (x) begin
                  if (mode) begin
                     w_ovf = 1'b1;
                  end else begin
                     w_state = COUNT;
                     w_count = '0;
                  end
               end
            end
            default: begin
               w_state = IDLE;
               w_count = '0;
            end
         endcase
      end
      // y is a registered decode of the next state, so it tracks TERM exactly.
      w_y = (w_state == TERM);
   end

   assign y       = r_y;
   assign y_pulse = r_pulse;
   assign count   = r_count;
   assign ovf     = r_ovf;
   assign state   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_x_event_counter_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_x_event_counter_fsm
//  Purpose  : Directed, table-driven self-checking bench for x_event_counter_fsm.
//  Revision : 1.0  initial release
// ============================================================================
module tb_x_event_counter_fsm;

   localparam int WIDTH = 2;

   logic             clk;
   logic             rst_n;
   logic             en;
   logic             clr;
   logic             x;
   logic             mode;
   logic [WIDTH-1:0] term_cnt;
   logic             y;
   logic             y_pulse;
   logic [WIDTH-1:0] count;
   logic             ovf;
   logic [1:0]       state;

   int total;
   int bad;

   typedef struct {
      logic             en;
      logic             clr;
      logic             x;
      logic             mode;
      logic [WIDTH-1:0] tc;
      logic [1:0]       e_state;
      logic [WIDTH-1:0] e_count;
      logic             e_y;
      logic             e_pulse;
      logic             e_ovf;
   } vec_t;

   vec_t vq[$];

   x_event_counter_fsm #(.WIDTH(WIDTH)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .clr      (clr),
      .x        (x),
      .mode     (mode),
      .term_cnt (term_cnt),
      .y        (y),
      .y_pulse  (y_pulse),
      .count    (count),
      .ovf      (ovf),
      .state    (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic add(input logic a_en, input logic a_clr, input logic a_x,
                      input logic a_mode, input logic [WIDTH-1:0] a_tc,
                      input logic [1:0] s, input logic [WIDTH-1:0] c,
                      input logic yy, input logic p, input logic o);
      vec_t v;
      v.en = a_en; v.clr = a_clr; v.x = a_x; v.mode = a_mode; v.tc = a_tc;
      v.e_state = s; v.e_count = c; v.e_y = yy; v.e_pulse = p; v.e_ovf = o;
      vq.push_back(v);
   endtask

   task automatic check(input string name, input logic [1:0] s,
                        input logic [WIDTH-1:0] c, input logic yy,
                        input logic p, input logic o);
      total++;
      if ({state, count, y, y_pulse, ovf} !== {s, c, yy, p, o}) begin
         bad++;
         $display("FAIL %s: got state=%b count=%0d y=%b pulse=%b ovf=%b, want state=%b count=%0d y=%b pulse=%b ovf=%b",
                  name, state, count, y, y_pulse, ovf, s, c, yy, p, o);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      // en clr x mode tc | state count y pulse ovf
      // reset release, en=0 holds IDLE
      add(0,0,1,0,3, 2'b00,0,0,0,0);
      // wrap mode, tc=3: first enabled edge only leaves IDLE
      add(1,0,1,0,3, 2'b01,0,0,0,0);
      add(1,0,1,0,3, 2'b01,1,0,0,0);
      add(1,0,1,0,3, 2'b01,2,0,0,0);
      add(1,0,1,0,3, 2'b10,3,1,1,0);
      add(1,0,1,0,3, 2'b01,0,0,0,0);
      add(1,0,1,0,3, 2'b01,1,0,0,0);
      add(1,0,1,0,3, 2'b01,2,0,0,0);
      add(1,0,1,0,3, 2'b10,3,1,1,0);
      add(1,0,1,0,3, 2'b01,0,0,0,0);
      // stop mode: saturate at 3, ovf from the 4th event
      add(1,0,1,1,3, 2'b01,1,0,0,0);
      add(1,0,1,1,3, 2'b01,2,0,0,0);
      add(1,0,1,1,3, 2'b10,3,1,1,0);
      add(1,0,1,1,3, 2'b10,3,1,0,1);
      add(1,0,1,1,3, 2'b10,3,1,0,1);
      add(1,0,1,1,3, 2'b10,3,1,0,1);
      add(1,1,0,1,3, 2'b00,0,0,0,0);
      // pause freezes count at 2
      add(1,0,0,0,3, 2'b01,0,0,0,0);
      add(1,0,1,0,3, 2'b01,1,0,0,0);
      add(1,0,1,0,3, 2'b01,2,0,0,0);
      add(0,0,1,0,3, 2'b01,2,0,0,0);
      add(0,0,0,0,3, 2'b01,2,0,0,0);
      add(0,0,1,0,3, 2'b01,2,0,0,0);
      add(0,0,0,0,3, 2'b01,2,0,0,0);
      add(0,0,1,0,3, 2'b01,2,0,0,0);
      add(1,0,1,0,3, 2'b10,3,1,1,0);
      // clr beats a simultaneous x
      add(1,1,1,0,3, 2'b00,0,0,0,0);
      // term_cnt change after latching is ignored
      add(1,0,0,0,3, 2'b01,0,0,0,0);
      add(1,0,1,0,1, 2'b01,1,0,0,0);
      add(1,0,1,0,1, 2'b01,2,0,0,0);
      add(1,0,1,0,1, 2'b10,3,1,1,0);
      add(1,1,0,0,1, 2'b00,0,0,0,0);
      // term_cnt=0 coerced to 1
      add(1,0,0,0,0, 2'b01,0,0,0,0);
      add(1,0,1,0,0, 2'b10,1,1,1,0);
      add(1,0,0,0,0, 2'b10,1,1,0,0);
      add(1,0,1,0,0, 2'b01,0,0,0,0);
      // mode switched to STOP while in TERM
      add(1,0,1,0,0, 2'b10,1,1,1,0);
      add(1,0,1,1,0, 2'b10,1,1,0,1);

      rst_n = 1'b0; en = 1'b0; clr = 1'b0; x = 1'b0; mode = 1'b0; term_cnt = '0;
      #2;
      check("reset", 2'b00, 0, 0, 0, 0);
      @(posedge clk); #3;
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < vq.size(); i++) begin
         en = vq[i].en; clr = vq[i].clr; x = vq[i].x;
         mode = vq[i].mode; term_cnt = vq[i].tc;
         @(posedge clk); #1;
         check($sformatf("row%0d", i), vq[i].e_state, vq[i].e_count,
               vq[i].e_y, vq[i].e_pulse, vq[i].e_ovf);
      end

      // asynchronous reset mid-cycle while in TERM with ovf set
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst", 2'b00, 0, 0, 0, 0);
      #2;
      en = 1'b0; x = 1'b1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_idle", 2'b00, 0, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
